mdc_fft_ctrl: RTL and testbench

- Sequencing controller for the 32-point radix-2 MDC FFT datapath.
- Input arrives as two rails, so one frame is 16 consecutive di_en cycles.
- The delay lines and butterflies free-run every clock, so this block only tracks where each frame is. It does this with a tag pipeline that drives per-stage butterfly enables, commutator selects, twiddle addresses and output framing.
- It also detects broken (gapped) frames and suppresses their output.

---
 rtl/mdc_fft_ctrl_pkg.sv | 40 ++++
 rtl/mdc_fft_ctrl_if.sv | 22 ++
 rtl/mdc_fft_ctrl_tag_pipe.sv | 42 ++++
 rtl/mdc_fft_ctrl.sv | 105 ++++++++++
 tb/tb_mdc_fft_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mdc_fft_ctrl_pkg.sv
// mdc_fft_pkg: constants, tag layout and pipeline offset helpers shared by the
// 32-point radix-2 MDC FFT controller and its datapath.
//   t_stage(s, bf, tw) : cycle offset at which stage s sees an input pair
//   t_out(bf, tw)      : cycle offset at which an input pair leaves the FFT
package mdc_fft_pkg;

  localparam int unsigned N      = 32;
  localparam int unsigned LOG2N  = 5;
  localparam int unsigned PAIRS  = 16;
  localparam int unsigned NSTAGE = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TAG_W  = CNT_W + 2;

  // v: pair valid, p: frame parity, c: pair index within frame
  typedef struct packed {
    logic             v;
    logic             p;
    logic [CNT_W-1:0] c;
  } tag_t;

  // Delay-line length in front of stage s.
  function automatic int unsigned d_stage(input int unsigned s);
    return 32'd8 >> s;
  endfunction

  function automatic int unsigned t_stage(input int unsigned s,
                                          input int unsigned bf_lat,
                                          input int unsigned tw_lat);
    int unsigned t;
    t = 0;
    for (int unsigned i = 0; i < s; i++) t += bf_lat + tw_lat + d_stage(i);
    return t;
  endfunction

  function automatic int unsigned t_out(input int unsigned bf_lat,
                                        input int unsigned tw_lat);
    return t_stage(4, bf_lat, tw_lat) + bf_lat;
  endfunction

endpackage

// File: rtl/mdc_fft_ctrl_if.sv
// mdc_fft_ctrl_if: input strobe and sequencing outputs of the MDC FFT
// controller.
//   master : drives di_en, observes the sequencing outputs (data source side)
//   slave  : the controller itself
interface mdc_fft_ctrl_if;
  logic        di_en;
  logic [4:0]  bf_en;
  logic [3:0]  sw_sel;
  logic [15:0] tw_addr;
  logic        do_en;
  logic [3:0]  do_cnt;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  modport master (output di_en,
                  input  bf_en, sw_sel, tw_addr, do_en, do_cnt,
                         frame_done, frame_err, busy);
  modport slave  (input  di_en,
                  output bf_en, sw_sel, tw_addr, do_en, do_cnt,
                         frame_done, frame_err, busy);
endinterface

// File: rtl/mdc_fft_ctrl_tag_pipe.sv
// mdc_tag_pipe: shift chain of frame-position tags with a tap at every
// position. Position 0 is the tag entering this cycle; position k is the tag
// that entered k cycles ago. A flush clears v of every tag with matching
// parity as it moves to the next position.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_i         : tag entering position 0
//   flush_en_i   : clear matching-parity tags on this edge
//   flush_par_i  : parity of the frame being flushed
//   taps_o       : tags at positions 0..DEPTH-1
module mdc_tag_pipe
  import mdc_fft_pkg::*;
#(
  parameter int unsigned DEPTH = 29
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  tag_t                   in_i,
  input  logic                   flush_en_i,
  input  logic                   flush_par_i,
  output tag_t [DEPTH-1:0]       taps_o
);

  tag_t [DEPTH-1:1] tag_q, tag_d;
  tag_t [DEPTH-1:0] taps;

  assign taps   = {tag_q, in_i};
  assign taps_o = taps;

  always_comb begin
    tag_d = '0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      tag_d[k] = taps[k-1];
      if (flush_en_i && (taps[k-1].p == flush_par_i)) tag_d[k].v = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_q <= '0;
    else        tag_q <= tag_d;
  end

endmodule

// File: rtl/mdc_fft_ctrl.sv
// mdc_fft_ctrl: sequencing controller for the 32-point radix-2 MDC FFT.
// Tracks each input pair through the free-running datapath with a tag
// pipeline and decodes butterfly enables, commutator selects, twiddle
// addresses and output framing; aborts and suppresses gapped frames.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.di_en  : input pair valid
//   bus.bf_en / sw_sel / tw_addr : per-stage datapath controls
//   bus.do_en / do_cnt / frame_done : output framing
//   bus.frame_err : pulse after an aborted frame; bus.busy : work in flight
module mdc_fft_ctrl
  import mdc_fft_pkg::*;
#(
  parameter int unsigned BF_LAT = 1,
  parameter int unsigned TW_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mdc_fft_ctrl_if.slave   bus
);

  localparam int unsigned T_OUT = t_out(BF_LAT, TW_LAT);
  localparam int unsigned DEPTH = T_OUT + 1;

  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic             parity_q, parity_d;
  logic             frame_err_q;
  logic             abort;
  tag_t             tag_in;
  tag_t [DEPTH-1:0] taps;
  tag_t             t_o;
  logic [4:0]       bf_en;
  logic [3:0]       sw_sel;
  logic [15:0]      tw_addr;
  logic             any_v;

  always_comb begin
    abort    = ~bus.di_en & (in_cnt_q != '0);
    in_cnt_d = in_cnt_q;
    parity_d = parity_q;
    if (abort) begin
      in_cnt_d = '0;
      parity_d = ~parity_q;
    end else if (bus.di_en) begin
      in_cnt_d = in_cnt_q + 1'b1;
      if (in_cnt_q == '1) parity_d = ~parity_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q    <= '0;
      parity_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      parity_q    <= parity_d;
      frame_err_q <= abort;
    end
  end

  // Position 0 is unregistered, so the entering tag is gated by reset to keep
  // every output low while rst_n is asserted.
  always_comb begin
    tag_in.v = bus.di_en & rst_n;
    tag_in.p = parity_q;
    tag_in.c = in_cnt_q;
  end

  mdc_tag_pipe #(.DEPTH(DEPTH)) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_i        (tag_in),
    .flush_en_i  (abort),
    .flush_par_i (parity_q),
    .taps_o      (taps)
  );

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    localparam int unsigned TS = t_stage(s, BF_LAT, TW_LAT);
    tag_t t_s;
    assign t_s      = taps[TS];
    assign bf_en[s] = t_s.v;
    if (s < 4) begin : g_cm
      localparam logic [3:0] MASK = 4'(2 * d_stage(s) - 1);
      assign sw_sel[s]         = t_s.v & t_s.c[3-s];
      assign tw_addr[4*s +: 4] = t_s.v ? 4'((t_s.c & MASK) << s) : 4'h0;
    end
  end

  always_comb begin
    any_v = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) any_v = any_v | taps[k].v;
  end

  assign t_o            = taps[T_OUT];
  assign bus.bf_en      = bf_en;
  assign bus.sw_sel     = sw_sel;
  assign bus.tw_addr    = tw_addr;
  assign bus.do_en      = t_o.v;
  assign bus.do_cnt     = t_o.v ? t_o.c : '0;
  assign bus.frame_done = t_o.v & (t_o.c == '1);
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (in_cnt_q != '0) | any_v;

endmodule

// File: tb/tb_mdc_fft_ctrl.sv
module tb_mdc_fft_ctrl;

  localparam int MAXC  = 4096;
  localparam int BF    = 1;
  localparam int TW    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdc_fft_ctrl_if bus ();

  mdc_fft_ctrl #(.BF_LAT(1), .TW_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  // reference model: history of every input cycle (valid, parity, index)
  logic       hv [MAXC];
  logic       hp [MAXC];
  logic [3:0] hc [MAXC];
  int   T [5];
  int   TOUT;
  int   m_cnt;
  logic m_par;
  logic m_err_pend;
  logic in_reset;

  // per-test recordings of DUT outputs indexed by cycle relative to t0
  logic [4:0]  r_bf   [256];
  logic [3:0]  r_sw   [256];
  logic [15:0] r_tw   [256];
  logic        r_do   [256];
  logic [3:0]  r_cnt  [256];
  logic        r_fd   [256];
  logic        r_err  [256];
  logic        r_busy [256];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MAXC; i++) hv[i] = 1'b0;
    m_cnt      = 0;
    m_par      = 1'b0;
    m_err_pend = 1'b0;
  endtask

  // one clock cycle: drive di, check at negedge against the model, advance
  task automatic step(input logic di);
    logic [4:0]  ebf;
    logic [3:0]  esw;
    logic [15:0] etw;
    logic        edo, efd, ebusy;
    logic [3:0]  ecnt;
    int          age, rel, a;
    bit          abort;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: observed %0d expected < %0d", cyc, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    bus.di_en = di;
    @(negedge clk);
    hv[cyc] = di & ~in_reset;
    hp[cyc] = m_par;
    hc[cyc] = 4'(m_cnt);
    ebf = '0; esw = '0; etw = '0;
    for (int s = 0; s < 5; s++) begin
      a = cyc - T[s];
      if (a >= 0 && hv[a]) begin
        ebf[s] = 1'b1;
        if (s < 4) begin
          esw[s] = ((int'(hc[a]) / (8 >> s)) % 2) == 1;
          etw[4*s +: 4] = 4'(((int'(hc[a]) % (2 * (8 >> s))) * (1 << s)) % 16);
        end
      end
    end
    a    = cyc - TOUT;
    edo  = (a >= 0) && hv[a];
    ecnt = edo ? hc[a] : 4'd0;
    efd  = edo && (hc[a] == 4'd15);
    ebusy = (m_cnt != 0);
    for (age = 0; age <= TOUT; age++)
      if (cyc - age >= 0 && hv[cyc-age]) ebusy = 1'b1;

    chk("bf_en",      bus.bf_en,      ebf);
    chk("sw_sel",     bus.sw_sel,     esw);
    chk("tw_addr",    bus.tw_addr,    etw);
    chk("do_en",      bus.do_en,      edo);
    chk("do_cnt",     bus.do_cnt,     ecnt);
    chk("frame_done", bus.frame_done, efd);
    chk("frame_err",  bus.frame_err,  m_err_pend);
    chk("busy",       bus.busy,       ebusy);

    rel = cyc - t0;
    if (rel >= 0 && rel < 256) begin
      r_bf[rel] = bus.bf_en;   r_sw[rel] = bus.sw_sel;  r_tw[rel] = bus.tw_addr;
      r_do[rel] = bus.do_en;   r_cnt[rel] = bus.do_cnt; r_fd[rel] = bus.frame_done;
      r_err[rel] = bus.frame_err; r_busy[rel] = bus.busy;
    end

    if (in_reset) begin
      m_cnt = 0; m_par = 1'b0; m_err_pend = 1'b0;
    end else begin
      abort = !di && (m_cnt != 0);
      if (abort) begin
        for (age = 0; age < TOUT; age++)
          if (cyc - age >= 0 && hp[cyc-age] == m_par) hv[cyc-age] = 1'b0;
        m_cnt = 0;
        m_par = ~m_par;
      end else if (di) begin
        if (m_cnt == 15) m_par = ~m_par;
        m_cnt = (m_cnt + 1) % 16;
      end
      m_err_pend = abort;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    t0 = cyc;
    for (int i = 0; i < 256; i++) begin
      r_bf[i] = 'x; r_sw[i] = 'x; r_tw[i] = 'x; r_do[i] = 'x;
      r_cnt[i] = 'x; r_fd[i] = 'x; r_err[i] = 'x; r_busy[i] = 'x;
    end
  endtask

  initial begin
    int cnt_fd, cnt_err, len;
    T[0] = 0;
    for (int s = 0; s < 4; s++) T[s+1] = T[s] + BF + TW + (8 >> s);
    TOUT = T[4] + BF;
    bus.di_en = 1'b0;
    in_reset  = 1'b1;
    model_reset();

    // power-on reset
    repeat (3) step(1'b0);
    rst_n = 1'b1; in_reset = 1'b0;

    // idle: everything stays low
    repeat (40) step(1'b0);

    // single frame
    start_test();
    repeat (16) step(1'b1);
    repeat (40) step(1'b0);
    chk("sf_bf0_first", r_bf[0][0], 1);   chk("sf_bf0_last", r_bf[15][0], 1);
    chk("sf_bf0_after", r_bf[16][0], 0);
    chk("sf_sw0_7", r_sw[7][0], 0);       chk("sf_sw0_8", r_sw[8][0], 1);
    chk("sf_sw0_15", r_sw[15][0], 1);
    chk("sf_bf1_10", r_bf[10][1], 0);     chk("sf_bf1_11", r_bf[11][1], 1);
    chk("sf_bf1_26", r_bf[26][1], 1);     chk("sf_bf1_27", r_bf[27][1], 0);
    chk("sf_do_27", r_do[27], 0);
    for (int i = 0; i < 16; i++) begin
      chk("sf_do", r_do[28+i], 1);
      chk("sf_do_cnt", r_cnt[28+i], 16'(i));
      chk("sf_tw1", r_tw[11+i][7:4], 16'((i % 8) * 2));
      chk("sf_tw3", r_tw[23+i][15:12], 16'((i % 2) * 8));
    end
    chk("sf_do_44", r_do[44], 0);
    chk("sf_fd_43", r_fd[43], 1);         chk("sf_fd_42", r_fd[42], 0);
    chk("sf_busy_43", r_busy[43], 1);     chk("sf_busy_44", r_busy[44], 0);

    // back-to-back: three frames without a gap
    start_test();
    repeat (48) step(1'b1);
    repeat (40) step(1'b0);
    chk("bb_do_27", r_do[27], 0);
    for (int i = 28; i <= 75; i++) chk("bb_do", r_do[i], 1);
    chk("bb_do_76", r_do[76], 0);
    cnt_fd = 0;
    for (int i = 0; i < 88; i++) cnt_fd += int'(r_fd[i]);
    chk("bb_fd_count", 16'(cnt_fd), 3);
    chk("bb_fd_43", r_fd[43], 1); chk("bb_fd_59", r_fd[59], 1); chk("bb_fd_75", r_fd[75], 1);

    // abort: A complete, B 5 pairs then gap, clean frame from cycle 30
    start_test();
    repeat (21) step(1'b1);
    repeat (9)  step(1'b0);
    repeat (16) step(1'b1);
    repeat (40) step(1'b0);
    chk("ab_err_22", r_err[22], 1);
    cnt_err = 0;
    for (int i = 0; i < 86; i++) cnt_err += int'(r_err[i]);
    chk("ab_err_count", 16'(cnt_err), 1);
    for (int i = 0; i < 16; i++) chk("ab_a_cnt", r_cnt[28+i], 16'(i));
    for (int i = 44; i < 58; i++) chk("ab_b_suppressed", r_do[i], 0);
    chk("ab_c_do_58", r_do[58], 1);   chk("ab_c_cnt_58", r_cnt[58], 0);
    chk("ab_c_fd_73", r_fd[73], 1);

    // reset mid-frame
    start_test();
    repeat (6) step(1'b1);
    rst_n = 1'b0; in_reset = 1'b1;
    model_reset();
    step(1'b1);
    chk("rst_bf_now", r_bf[6], 0);
    chk("rst_busy_now", r_busy[6], 0);
    repeat (2) step(1'b0);
    rst_n = 1'b1; in_reset = 1'b0;
    repeat (5) step(1'b0);
    start_test();
    repeat (16) step(1'b1);
    repeat (40) step(1'b0);
    chk("rst_fresh_do_28", r_do[28], 1);  chk("rst_fresh_cnt_28", r_cnt[28], 0);
    chk("rst_fresh_fd_43", r_fd[43], 1);  chk("rst_fresh_busy_44", r_busy[44], 0);
    cnt_err = 0;
    for (int i = 0; i < 56; i++) cnt_err += int'(r_err[i]);
    chk("rst_no_err", 16'(cnt_err), 0);

    // randomized frames, partial frames and idle stretches
    repeat (60) begin
      if ($urandom_range(0, 3) == 0) begin
        len = $urandom_range(1, 20);
        repeat (len) step(1'b0);
      end else begin
        len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 16 * $urandom_range(1, 2);
        repeat (len) step(1'b1);
        if ($urandom_range(0, 1) == 0) step(1'b0);
      end
    end
    repeat (40) step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
